// File: rtl/uart_pixel_rx.sv
// UART 8N1 receiver feeding a 1-bit pixel stream (MSB of each byte first),
// with frame-boundary pulse and line error flags.
module uart_pixel_rx #(
  parameter int CLKS_PER_BIT     = 434,
  parameter int PIXELS_PER_FRAME = 784,
  parameter int CNT_W            = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic pixel_bit,
  output logic pixel_bit_valid,
  input  logic pixel_bit_ready,
  output logic frame_done,
  output logic framing_error,
  output logic overrun,
  output logic rx_busy
);

  localparam logic [CNT_W-1:0] LP_BIT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_PIX_MAX  = CNT_W'(PIXELS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_rx_meta, r_rx_s;
  logic             r_framing_error;

  logic [7:0]       r_pix_sh;
  logic [3:0]       r_rem;
  logic             r_overrun;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_frame_done;

  logic w_xfer, w_empty, w_byte_ok;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_baud          <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_framing_error <= 1'b0;
    end else begin
      r_framing_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (!r_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_baud == LP_HALF_MAX) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == LP_BIT_MAX) begin
            r_baud    <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == LP_BIT_MAX) begin
            r_baud <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= S_WAIT_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_xfer    = (r_rem != 4'd0) && pixel_bit_ready;
  assign w_byte_ok = (r_state == S_STOP) && (r_baud == LP_BIT_MAX) && r_rx_s;
  // Unpacker draining its last bit this cycle counts as empty.
  assign w_empty   = (r_rem == 4'd0) || ((r_rem == 4'd1) && w_xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_sh  <= '0;
      r_rem     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_byte_ok && !w_empty;
      if (w_byte_ok && w_empty) begin
        r_pix_sh <= r_shift;
        r_rem    <= 4'd8;
      end else if (w_xfer) begin
        r_pix_sh <= {r_pix_sh[6:0], 1'b0};
        r_rem    <= r_rem - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_xfer) begin
        if (r_frame_cnt == LP_PIX_MAX) begin
          r_frame_cnt  <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign pixel_bit       = r_pix_sh[7];
  assign pixel_bit_valid = (r_rem != 4'd0);
  assign frame_done      = r_frame_done;
  assign framing_error   = r_framing_error;
  assign overrun         = r_overrun;
  assign rx_busy         = (r_state != S_IDLE);

endmodule

// File: doc/uart_pixel_rx.md
Name: uart_pixel_rx

Overview:
- UART 8N1 receiver and bit unpacker that feeds pixel_serial_loader directly.
- Receives packed binary pixel bytes from the host link: 8 pixels per byte, MSB = earliest pixel.
- Presents the pixels one bit at a time on a valid/ready stream, matching the loader's pixel_bit, pixel_bit_valid and pixel_bit_ready ports.
- Tracks frame boundaries and flags line errors.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- PIXELS_PER_FRAME, 784, pixels per frame; must be a multiple of 8.
- CNT_W, 16, width of the baud counter and the frame pixel counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- uart_rx  in  1  asynchronous serial line, idle high.
- pixel_bit  out  1  current pixel value.
- pixel_bit_valid  out  1  pixel_bit holds an undelivered pixel.
- pixel_bit_ready  in  1  downstream accepts the pixel this cycle.
- frame_done  out  1  1-cycle pulse on the transfer of the last pixel of a frame.
- framing_error  out  1  1-cycle pulse when the stop bit samples 0.
- overrun  out  1  1-cycle pulse when a received byte is dropped.
- rx_busy  out  1  RX FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; counters 0.
  - Unpacker empty.
  - Synchronizer flops set to 1 (line idle).
- Reset mid-byte or mid-unpack discards all partial data; there is no recovery state.
- Synchronizer: 2-flop on uart_rx → rx_s. All RX decisions use rx_s, so there is 2 cycles of input latency.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 → START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - 0 → DATA, counter cleared, bit index 0.
    - 1 → IDLE (glitch rejected, no error).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first (UART order). After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 → byte complete, go to IDLE.
    - 0 → framing_error pulse, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s==1, then IDLE.
- rx_busy = (state != IDLE).
- Byte hand-off, on the byte-complete cycle:
  - Unpacker empty: the byte loads into the unpacker the next cycle, and pixel_bit_valid rises that same cycle.
  - Unpacker still holds undelivered bits: overrun pulse, new byte dropped, unpacker contents untouched.
- Unpacker:
  - 8-bit shift register plus a 4-bit remaining count.
  - pixel_bit = shreg[7], so the byte's MSB is delivered first.
  - pixel_bit_valid = (remaining != 0).
  - On valid && ready: shift left 1 and decrement remaining.
  - pixel_bit and pixel_bit_valid are stable while valid is high and ready is low.
  - Full throughput is 1 bit/cycle under continuous ready.
- Simultaneous events:
  - A byte completing in the same cycle the last bit transfers counts as empty. The byte is accepted with no overrun, loads next cycle, and gives at most one bubble cycle of valid low.
- Frame counter:
  - Increments on each valid && ready.
  - On the transfer where count == PIXELS_PER_FRAME-1: frame_done pulses that same cycle (registered, visible next edge) and the counter wraps to 0.
- Framing errors and overruns do not adjust the frame counter. Host-side resync is done by reset.
- Arithmetic widths:
  - Baud counter: CNT_W bits, compared against CLKS_PER_BIT-1 (truncated to CNT_W).
  - Frame counter: CNT_W bits.

Test Plan:
- Single byte: CLKS_PER_BIT=4, send 0xA5, hold ready=1 → pixel_bit sequence 1,0,1,0,0,1,0,1. Valid high for exactly 8 cycles; no error pulses.
- Backpressure: send 0xF0, hold ready low for 20 cycles after valid rises → pixel_bit=1 and valid=1 held stable; release → 1,1,1,1,0,0,0,0.
- Overrun: send 0xFF, then 0x00 back-to-back with ready=0 throughout → overrun pulses once at the second stop bit. On release, 8 ones are delivered and no zeros.
- Framing error and glitch:
  - Send 0x3C with the stop bit forced 0 → framing_error pulse, no pixels; rx_busy stays high until the line returns high.
  - A 1-cycle low glitch → no START acceptance and no output.
- Frame boundary: PIXELS_PER_FRAME=16, send 3 bytes with ready=1 → frame_done pulses on the 16th pixel transfer only. The 17th pixel starts a new count.
- Reset mid-byte: assert rst during DATA bit 4 → all outputs 0 immediately. The next clean byte 0x81 is delivered correctly as 1,0,0,0,0,0,0,1.
